// File: rtl/quire_to_posit_4_0.sv
// rtl/quire_to_posit_4_0.sv - rounds the 20-bit posit<4,0> quire to a 4-bit posit
// 3-stage pipeline behind a one-entry skid register; optional end-of-window filtering.
module quire_to_posit_4_0 #(
  parameter bit ONLY_EOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rts_i,
  output logic        rtr_o,
  input  logic        sow_i,
  input  logic        eow_i,
  input  logic [19:0] data_i,
  input  logic        sign_i,
  input  logic        zero_i,
  input  logic        NaR_i,
  input  logic        rtr_i,
  output logic        rts_o,
  output logic        sow_o,
  output logic        eow_o,
  output logic [3:0]  posit_o
);

  logic        r_rtr;
  logic [2:0]  r_staged;

  logic        r_skid_full;
  logic [19:0] r_skid_data;
  logic        r_skid_sign, r_skid_zero, r_skid_nar, r_skid_sow, r_skid_eow;

  logic [19:0] r_s1_m;
  logic        r_s1_sign, r_s1_zero, r_s1_nar, r_s1_sow, r_s1_eow;

  logic [3:0]  r_s2_p;
  logic        r_s2_sign, r_s2_zero, r_s2_nar, r_s2_sow, r_s2_eow;

  logic [3:0]  r_posit;
  logic        r_sow, r_eow;

  logic        w_process_en, w_xfer, w_in_valid, w_keep;
  logic [19:0] w_in_data, w_in_m;
  logic        w_in_sign, w_in_zero, w_in_nar, w_in_sow, w_in_eow;
  logic [3:0]  w_p, w_posit;

  assign w_process_en = rtr_i | ~r_staged[2];
  assign w_xfer       = rts_i & r_rtr;

  // A parked skid word always wins stage 1; no transfer can coincide with it since rtr_o is low.
  assign w_in_valid = r_skid_full | w_xfer;
  assign w_in_data  = r_skid_full ? r_skid_data : data_i;
  assign w_in_sign  = r_skid_full ? r_skid_sign : sign_i;
  assign w_in_zero  = r_skid_full ? r_skid_zero : zero_i;
  assign w_in_nar   = r_skid_full ? r_skid_nar  : NaR_i;
  assign w_in_sow   = r_skid_full ? r_skid_sow  : sow_i;
  assign w_in_eow   = r_skid_full ? r_skid_eow  : eow_i;
  assign w_keep     = ~ONLY_EOW | w_in_eow;

  assign w_in_m = w_in_data[19] ? (~w_in_data + 20'd1) : w_in_data;

  // Magnitude in 1/16 units against the rounding midpoints between adjacent posits.
  always_comb begin
    w_p = 4'b0111;
    if      (r_s1_m <= 20'd5)  w_p = 4'b0001;
    else if (r_s1_m <= 20'd10) w_p = 4'b0010;
    else if (r_s1_m <= 20'd13) w_p = 4'b0011;
    else if (r_s1_m <= 20'd20) w_p = 4'b0100;
    else if (r_s1_m <= 20'd27) w_p = 4'b0101;
    else if (r_s1_m <= 20'd48) w_p = 4'b0110;
  end

  always_comb begin
    w_posit = r_s2_p;
    if (r_s2_nar)       w_posit = 4'b1000;
    else if (r_s2_zero) w_posit = 4'b0000;
    else if (r_s2_sign) w_posit = ~r_s2_p + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rtr       <= 1'b0;
      r_staged    <= 3'b000;
      r_skid_full <= 1'b0;
      r_skid_data <= '0;
      r_skid_sign <= 1'b0;
      r_skid_zero <= 1'b0;
      r_skid_nar  <= 1'b0;
      r_skid_sow  <= 1'b0;
      r_skid_eow  <= 1'b0;
      r_s1_m      <= '0;
      r_s1_sign   <= 1'b0;
      r_s1_zero   <= 1'b0;
      r_s1_nar    <= 1'b0;
      r_s1_sow    <= 1'b0;
      r_s1_eow    <= 1'b0;
      r_s2_p      <= '0;
      r_s2_sign   <= 1'b0;
      r_s2_zero   <= 1'b0;
      r_s2_nar    <= 1'b0;
      r_s2_sow    <= 1'b0;
      r_s2_eow    <= 1'b0;
      r_posit     <= '0;
      r_sow       <= 1'b0;
      r_eow       <= 1'b0;
    end else begin
      r_rtr <= w_process_en & ~r_skid_full;

      if (w_xfer && !w_process_en) begin
        r_skid_full <= 1'b1;
        r_skid_data <= data_i;
        r_skid_sign <= sign_i;
        r_skid_zero <= zero_i;
        r_skid_nar  <= NaR_i;
        r_skid_sow  <= sow_i;
        r_skid_eow  <= eow_i;
      end else if (w_process_en) begin
        r_skid_full <= 1'b0;
      end

      if (w_process_en) begin
        r_staged <= {r_staged[1:0], w_in_valid & w_keep};
        if (w_in_valid) begin
          r_s1_m    <= w_in_m;
          r_s1_sign <= w_in_sign;
          r_s1_zero <= w_in_zero;
          r_s1_nar  <= w_in_nar;
          r_s1_sow  <= w_in_sow;
          r_s1_eow  <= w_in_eow;
        end
        if (r_staged[0]) begin
          r_s2_p    <= w_p;
          r_s2_sign <= r_s1_sign;
          r_s2_zero <= r_s1_zero | (r_s1_m == 20'd0);
          r_s2_nar  <= r_s1_nar;
          r_s2_sow  <= r_s1_sow;
          r_s2_eow  <= r_s1_eow;
        end
        if (r_staged[1]) begin
          r_posit <= w_posit;
          r_sow   <= r_s2_sow;
          r_eow   <= r_s2_eow;
        end
      end
    end
  end

  assign rtr_o   = r_rtr;
  assign rts_o   = r_staged[2];
  assign sow_o   = r_sow;
  assign eow_o   = r_eow;
  assign posit_o = r_posit;

endmodule

// File: tb/tb_quire_to_posit_4_0.sv
// tb/tb_quire_to_posit_4_0.sv - self-checking bench for quire_to_posit_4_0
// Nearest-value rounding model plus scoreboard; a second instance exercises end-of-window filtering.
module tb_quire_to_posit_4_0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rts_i = 1'b0, sow_i = 1'b0, eow_i = 1'b0;
  logic        sign_i = 1'b0, zero_i = 1'b0, nar_i = 1'b0, rtr_i = 1'b1;
  logic [19:0] data_i = '0;
  logic        rtr_o, rts_o, sow_o, eow_o;
  logic [3:0]  posit_o;
  logic        b_rtr_o, b_rts_o, b_sow_o, b_eow_o;
  logic [3:0]  b_posit_o;

  always #5 clk = ~clk;

  quire_to_posit_4_0 #(.ONLY_EOW(1'b0)) u_all (
    .clk(clk), .rst_n(rst_n), .rts_i(rts_i), .rtr_o(rtr_o), .sow_i(sow_i), .eow_i(eow_i),
    .data_i(data_i), .sign_i(sign_i), .zero_i(zero_i), .NaR_i(nar_i), .rtr_i(rtr_i),
    .rts_o(rts_o), .sow_o(sow_o), .eow_o(eow_o), .posit_o(posit_o));

  quire_to_posit_4_0 #(.ONLY_EOW(1'b1)) u_eow (
    .clk(clk), .rst_n(rst_n), .rts_i(rts_i), .rtr_o(b_rtr_o), .sow_i(sow_i), .eow_i(eow_i),
    .data_i(data_i), .sign_i(sign_i), .zero_i(zero_i), .NaR_i(nar_i), .rtr_i(1'b1),
    .rts_o(b_rts_o), .sow_o(b_sow_o), .eow_o(b_eow_o), .posit_o(b_posit_o));

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] d;
    logic        z, n, so, eo;
    logic [3:0]  p;
  } vec_t;
  vec_t tbl[13];

  logic [5:0] exp_q[$];
  logic [5:0] out_log[$];
  int         out_cyc[$], in_cyc[$];
  int         n_out = 0, b_cnt = 0;
  logic [3:0] b_posit = '0;
  logic       b_eow = 1'b0;
  logic       prev_stall = 1'b0;
  logic [3:0] prev_posit = '0;
  logic [5:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pick the nearest representable posit; ties go to the even encoding.
  function automatic logic [3:0] model_posit(input logic [19:0] d, input logic z, input logic n);
    int vals[8] = '{0, 4, 8, 12, 16, 24, 32, 64};
    int v, mag, k, dlo, dhi, code;
    if (n) return 4'b1000;
    v = $signed(d);
    mag = (v < 0) ? -v : v;
    if (z || mag == 0) return 4'b0000;
    if (mag <= 4) code = 1;
    else if (mag >= 64) code = 7;
    else begin
      k = 1;
      while (vals[k+1] <= mag) k++;
      dlo = mag - vals[k];
      dhi = vals[k+1] - mag;
      if (dlo < dhi) code = k;
      else if (dhi < dlo) code = k + 1;
      else code = (k % 2 == 0) ? k : k + 1;
    end
    if (v < 0) code = (16 - code) % 16;
    return code[3:0];
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'd0, rts_o}, 32'd1);
        chk("hold_posit", {28'd0, posit_o}, {28'd0, prev_posit});
        chk("rtr_fall", {31'd0, rtr_o}, 32'd0);
      end
      if (rts_o && rtr_i) begin
        n_out++;
        out_log.push_back({posit_o, sow_o, eow_o});
        out_cyc.push_back(cyc);
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out: posit %b emitted with no word pending (cycle %0d)", posit_o, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if ({posit_o, sow_o, eow_o} !== mon_e) begin
            n_err++;
            $display("FAIL model: got posit/sow/eow %b, expected %b (cycle %0d)", {posit_o, sow_o, eow_o}, mon_e, cyc);
          end
        end
      end
      if (rts_i && rtr_o) begin
        exp_q.push_back({model_posit(data_i, zero_i, nar_i), sow_i, eow_i});
        in_cyc.push_back(cyc);
      end
      prev_stall = rts_o & ~rtr_i;
      prev_posit = posit_o;
      if (b_rts_o) begin
        b_cnt++;
        b_posit = b_posit_o;
        b_eow = b_eow_o;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [19:0] d, input logic z, input logic n, input logic so,
                      input logic eo, input int max_cyc, output bit ok);
    rts_i = 1'b1; data_i = d; sign_i = d[19]; zero_i = z; nar_i = n; sow_i = so; eow_i = eo;
    ok = 1'b0;
    for (int k = 0; k < max_cyc && !ok; k++) begin
      @(negedge clk);
      ok = rtr_o;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit rnd_on;
    int base_out, base_in, snap, gap, mag;
    logic [19:0] d;

    tbl[0]  = '{20'd16,      1'b0, 1'b0, 1'b1, 1'b1, 4'b0100};
    tbl[1]  = '{20'd24,      1'b0, 1'b0, 1'b0, 1'b1, 4'b0101};
    tbl[2]  = '{20'hFFFF0,   1'b0, 1'b0, 1'b0, 1'b1, 4'b1100};
    tbl[3]  = '{20'h80000,   1'b0, 1'b0, 1'b0, 1'b1, 4'b1001};
    tbl[4]  = '{20'd3,       1'b0, 1'b0, 1'b0, 1'b1, 4'b0001};
    tbl[5]  = '{20'd6,       1'b0, 1'b0, 1'b0, 1'b1, 4'b0010};
    tbl[6]  = '{20'd10,      1'b0, 1'b0, 1'b0, 1'b1, 4'b0010};
    tbl[7]  = '{20'd20,      1'b0, 1'b0, 1'b0, 1'b1, 4'b0100};
    tbl[8]  = '{20'd28,      1'b0, 1'b0, 1'b0, 1'b1, 4'b0110};
    tbl[9]  = '{20'd48,      1'b0, 1'b0, 1'b0, 1'b1, 4'b0110};
    tbl[10] = '{20'd49,      1'b0, 1'b0, 1'b0, 1'b1, 4'b0111};
    tbl[11] = '{20'd16,      1'b0, 1'b1, 1'b0, 1'b1, 4'b1000};
    tbl[12] = '{20'd0,       1'b1, 1'b0, 1'b1, 1'b0, 4'b0000};

    // reset state
    wait_cyc(3);
    chk("rst_rtr", {31'd0, rtr_o}, 32'd0);
    chk("rst_rts", {31'd0, rts_o}, 32'd0);
    chk("rst_sow", {31'd0, sow_o}, 32'd0);
    chk("rst_eow", {31'd0, eow_o}, 32'd0);
    chk("rst_posit", {28'd0, posit_o}, 32'd0);
    chk("rst_b_rts", {31'd0, b_rts_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rtr_before_edge", {31'd0, rtr_o}, 32'd0);
    @(posedge clk); #1;
    chk("rtr_first_edge", {31'd0, rtr_o}, 32'd1);

    // table stream, no backpressure
    base_out = out_log.size();
    base_in = in_cyc.size();
    for (int i = 0; i < 13; i++) begin
      send(tbl[i].d, tbl[i].z, tbl[i].n, tbl[i].so, tbl[i].eo, 20, ok);
      chk("tbl_send", {31'd0, ok}, 32'd1);
    end
    rts_i = 1'b0;
    wait_cyc(6);
    chk("tbl_count", out_log.size() - base_out, 32'd13);
    for (int i = 0; i < 13; i++) begin
      if (base_out + i < out_log.size()) begin
        chk($sformatf("tbl_posit[%0d]", i), {28'd0, out_log[base_out+i][5:2]}, {28'd0, tbl[i].p});
        chk($sformatf("tbl_flags[%0d]", i), {30'd0, out_log[base_out+i][1:0]}, {30'd0, tbl[i].so, tbl[i].eo});
        chk($sformatf("tbl_latency[%0d]", i), out_cyc[base_out+i] - in_cyc[base_in+i], 32'd3);
      end
    end

    // end-of-window filter
    snap = b_cnt;
    send(20'd7, 1'b0, 1'b0, 1'b1, 1'b0, 20, ok);
    send(20'd9, 1'b0, 1'b0, 1'b0, 1'b0, 20, ok);
    send(20'd11, 1'b0, 1'b0, 1'b0, 1'b0, 20, ok);
    send(20'd40, 1'b0, 1'b0, 1'b0, 1'b1, 20, ok);
    rts_i = 1'b0;
    wait_cyc(8);
    chk("eow_count", b_cnt - snap, 32'd1);
    chk("eow_posit", {28'd0, b_posit}, 32'b0110);
    chk("eow_flag", {31'd0, b_eow}, 32'd1);

    // five-cycle stall with an incrementing stream
    snap = n_out;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(20'(4 + 6 * i), 1'b0, 1'b0, (i == 0), (i == 9), 30, ok);
          chk("stall_send", {31'd0, ok}, 32'd1);
        end
        rts_i = 1'b0;
      end
      begin
        wait_cyc(4);
        rtr_i = 1'b0;
        wait_cyc(5);
        rtr_i = 1'b1;
      end
    join
    wait_cyc(8);
    chk("stall_count", n_out - snap, 32'd10);
    chk("stall_drained", exp_q.size(), 32'd0);

    // randomized traffic with random backpressure
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          gap = $urandom_range(0, 2);
          if (gap > 0) begin
            rts_i = 1'b0;
            wait_cyc(gap);
          end
          if ($urandom_range(0, 3) == 0) d = 20'($urandom);
          else begin
            mag = $urandom_range(0, 70);
            d = ($urandom_range(0, 1) == 1) ? 20'(-mag) : 20'(mag);
          end
          send(d, (d == 20'd0), ($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), 60, ok);
          chk("rnd_send", {31'd0, ok}, 32'd1);
        end
        rts_i = 1'b0;
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          rtr_i = ($urandom_range(0, 3) != 0);
          wait_cyc(1);
        end
        rtr_i = 1'b1;
      end
    join
    wait_cyc(8);
    chk("rnd_drained", exp_q.size(), 32'd0);

    // reset with three words in flight and the skid register full
    rtr_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(20'(16 + 8 * i), 1'b0, 1'b0, 1'b1, 1'b1, 10, ok);
      chk("fill_send", {31'd0, ok}, 32'd1);
    end
    rts_i = 1'b0;
    chk("fill_rtr", {31'd0, rtr_o}, 32'd0);
    chk("fill_rts", {31'd0, rts_o}, 32'd1);
    rst_n = 1'b0;
    wait_cyc(1);
    rst_n = 1'b1;
    chk("mid_rst_rtr", {31'd0, rtr_o}, 32'd0);
    chk("mid_rst_rts", {31'd0, rts_o}, 32'd0);
    chk("mid_rst_sow", {31'd0, sow_o}, 32'd0);
    chk("mid_rst_eow", {31'd0, eow_o}, 32'd0);
    chk("mid_rst_posit", {28'd0, posit_o}, 32'd0);
    snap = n_out;
    rtr_i = 1'b1;
    wait_cyc(10);
    chk("no_stale_out", n_out - snap, 32'd0);
    send(20'hFFFE8, 1'b0, 1'b0, 1'b0, 1'b1, 20, ok);
    chk("recover_send", {31'd0, ok}, 32'd1);
    rts_i = 1'b0;
    wait_cyc(6);
    chk("recover_count", n_out - snap, 32'd1);
    chk("recover_posit", {28'd0, out_log[out_log.size()-1][5:2]}, 32'b1011);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
